// File: rtl/comparator_pkg.sv
// ============================================================================
// Module : comparator_pkg
// Brief  : Shared state encoding, result encoding and helpers for the serial
//          nibble-wise magnitude comparator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Result vectors are ordered {LT, EQ, GT} to match the output pins.
    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    localparam int NIB_W = 4;

    // Cascade resolution when every nibble compared equal; GT wins over LT
    // and the EQ input is deliberately not decoded.
    function automatic logic [2:0] resolve_cascade(input logic lt_in,
                                                   input logic gt_in);
        if (gt_in)
            return RES_GT;
        else if (lt_in)
            return RES_LT;
        else
            return RES_EQ;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_serial_nibble_cmp.sv
// ============================================================================
// Module : nibble_cmp
// Brief  : Combinational 4-bit unsigned magnitude compare (a<b, a>b).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_cmp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lt,
    output logic       gt
);

    assign lt = (a < b);
    assign gt = (a > b);

endmodule

`default_nettype wire

// File: rtl/comparator_serial.sv
// ============================================================================
// Module : comparator_serial
// Brief  : Serial magnitude comparator, one nibble per cycle MSB-first, with
//          cascade inputs and valid/ready handshakes on both sides.
//          Define COMPARATOR_SERIAL_EARLY_EXIT_EN to finish on the first
//          unequal nibble (latency only; results are identical).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module comparator_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             LT_IN,
    input  logic             EQ_IN,
    input  logic             GT_IN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             LT_OUT,
    output logic             EQ_OUT,
    output logic             GT_OUT
);

    import comparator_pkg::*;

    localparam int c_NIBBLES = WIDTH / NIB_W;
    localparam int c_IDX_W   = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(c_NIBBLES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] c_ST_COMPARE = 2'(COMPARE);
    localparam logic [1:0] c_ST_DONE    = 2'(DONE);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_cas;      // {LT_IN, EQ_IN, GT_IN}
    logic [c_IDX_W-1:0] r_idx;
    logic               r_decided;
    logic [2:0]         r_res;

    logic [NIB_W-1:0]   w_nib_a;
    logic [NIB_W-1:0]   w_nib_b;
    logic               w_lt;
    logic               w_gt;
    logic               w_last;
    logic               w_exit;
    logic               w_accept;
    logic               w_release;
    logic [2:0]         w_step_res;
    logic               w_step_decided;
    logic [2:0]         w_final_res;
    logic               w_unused_eq_in;

    assign w_nib_a = r_a[r_idx*NIB_W +: NIB_W];
    assign w_nib_b = r_b[r_idx*NIB_W +: NIB_W];

    nibble_cmp u_nibble_cmp (
        .a  (w_nib_a),
        .b  (w_nib_b),
        .lt (w_lt),
        .gt (w_gt)
    );

    assign w_last = (r_idx == '0);

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    assign w_exit = w_last || (!r_decided && (w_lt || w_gt));
`else
    assign w_exit = w_last;
`endif

    // Only the first unequal nibble (most significant) sets the result.
    always_comb begin
        w_step_res = r_res;
        if (!r_decided) begin
            if (w_gt)
                w_step_res = RES_GT;
            else if (w_lt)
                w_step_res = RES_LT;
        end
    end

    assign w_step_decided = r_decided || w_lt || w_gt;
    assign w_final_res    = w_step_decided ? w_step_res
                                           : resolve_cascade(r_cas[2], r_cas[0]);

    // The captured EQ cascade bit is kept for completeness but never decoded.
    assign w_unused_eq_in = r_cas[1];

    assign w_accept  = (r_state == c_ST_IDLE) && in_valid;
    assign w_release = (r_state == c_ST_DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cas     <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_res     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_cas     <= {LT_IN, EQ_IN, GT_IN};
                        r_idx     <= c_IDX_TOP;
                        r_decided <= 1'b0;
                        r_res     <= '0;
                        r_state   <= c_ST_COMPARE;
                    end
                end
                c_ST_COMPARE: begin
                    r_decided <= w_step_decided;
                    if (w_exit) begin
                        r_res   <= w_final_res;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_res <= w_step_res;
                        r_idx <= r_idx - 1'b1;
                    end
                end
                c_ST_DONE: begin
                    if (w_release) begin
                        r_res   <= '0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Status and result outputs decode straight from state so that reset
    // clears them without waiting for a clock edge.
    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign {LT_OUT, EQ_OUT, GT_OUT} = (r_state == c_ST_DONE) ? r_res : 3'b000;

endmodule

`default_nettype wire
